// File: rtl/issue_scheduler_pkg.sv
// Shared encodings for the dual-issue scheduler: alusel codes, FSM states and
// small decode helpers used by the scheduler and its hazard checker.
package issue_scheduler_pkg;

  localparam logic [2:0] ALUSEL_NOP    = 3'd0;
  localparam logic [2:0] ALUSEL_ALU    = 3'd1;
  localparam logic [2:0] ALUSEL_BRANCH = 3'd2;
  localparam logic [2:0] ALUSEL_LOAD   = 3'd3;
  localparam logic [2:0] ALUSEL_STORE  = 3'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } sched_state_e;

  function automatic logic is_mem(input logic [2:0] alusel);
    return (alusel == ALUSEL_LOAD) || (alusel == ALUSEL_STORE);
  endfunction

  // rd_addr packs {src2[4:0], src1[4:0]}; rd_en packs {src2, src1}
  function automatic logic reads_reg(input logic [1:0] rd_en,
                                     input logic [9:0] rd_addr,
                                     input logic [4:0] r);
    return (rd_en[0] && (rd_addr[4:0] == r)) || (rd_en[1] && (rd_addr[9:5] == r));
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Decode-queue head to scheduler bundle: the two oldest entries going in,
// the issue/consume masks coming back.
interface issue_scheduler_if;
  logic [1:0] head_valid;
  logic [2:0] head_alusel1;
  logic [2:0] head_alusel2;
  logic [1:0] head_rd_en1;
  logic [1:0] head_rd_en2;
  logic [9:0] head_rd_addr1;
  logic [9:0] head_rd_addr2;
  logic [1:0] head_wr_en;
  logic [4:0] head_wr_addr1;
  logic [4:0] head_wr_addr2;
  logic [1:0] head_is_privilege;
  logic [1:0] head_csr_write_en;
  logic [1:0] head_excp;
  logic [1:0] invalid_en;
  logic [1:0] issue_valid;

  modport master (
    output head_valid, head_alusel1, head_alusel2, head_rd_en1, head_rd_en2,
           head_rd_addr1, head_rd_addr2, head_wr_en, head_wr_addr1, head_wr_addr2,
           head_is_privilege, head_csr_write_en, head_excp,
    input  invalid_en, issue_valid
  );

  modport slave (
    input  head_valid, head_alusel1, head_alusel2, head_rd_en1, head_rd_en2,
           head_rd_addr1, head_rd_addr2, head_wr_en, head_wr_addr1, head_wr_addr2,
           head_is_privilege, head_csr_write_en, head_excp,
    output invalid_en, issue_valid
  );
endinterface

// File: rtl/issue_scheduler_pair_hazard_check.sv
// Combinational hazard terms for the head pair: intra-pair RAW, dual memory
// access and use of the load issued in the previous cycle.
module issue_scheduler_pair_hazard_check
  import issue_scheduler_pkg::*;
(
  input  logic       last_ld_vld,
  input  logic [4:0] last_ld_addr,
  input  logic [2:0] alusel1,
  input  logic [2:0] alusel2,
  input  logic [1:0] rd_en1,
  input  logic [9:0] rd_addr1,
  input  logic [1:0] rd_en2,
  input  logic [9:0] rd_addr2,
  input  logic       wr_en1,
  input  logic [4:0] wr_addr1,
  output logic       raw,
  output logic       mem_conflict,
  output logic       ld_use1,
  output logic       ld_use2
);

  assign raw          = wr_en1 && (wr_addr1 != 5'd0) && reads_reg(rd_en2, rd_addr2, wr_addr1);
  assign mem_conflict = is_mem(alusel1) && is_mem(alusel2);
  assign ld_use1      = last_ld_vld && reads_reg(rd_en1, rd_addr1, last_ld_addr);
  assign ld_use2      = last_ld_vld && reads_reg(rd_en2, rd_addr2, last_ld_addr);

endmodule

// File: rtl/issue_scheduler.sv
// Dual in-order issue from the decode queue head into execute, with a drain
// FSM that serializes privileged/CSR/excepting entries, and perf counters.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  issue_scheduler_if.slave     head_if,
  input  logic                 ex_pause,
  input  logic                 backend_empty,
  output logic                 serial_busy,
  output logic [CNT_WIDTH-1:0] dual_issue_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  sched_state_e state, next_state;
  logic         last_ld_vld;
  logic [4:0]   last_ld_addr;
  logic         raw, mem_conflict, ld_use1, ld_use2;
  logic         serial1, serial2;
  logic         slot1, slot2;
  logic         ld_take;
  logic [4:0]   ld_addr;

  issue_scheduler_pair_hazard_check u_hazard (
    .last_ld_vld  (last_ld_vld),
    .last_ld_addr (last_ld_addr),
    .alusel1      (head_if.head_alusel1),
    .alusel2      (head_if.head_alusel2),
    .rd_en1       (head_if.head_rd_en1),
    .rd_addr1     (head_if.head_rd_addr1),
    .rd_en2       (head_if.head_rd_en2),
    .rd_addr2     (head_if.head_rd_addr2),
    .wr_en1       (head_if.head_wr_en[0]),
    .wr_addr1     (head_if.head_wr_addr1),
    .raw          (raw),
    .mem_conflict (mem_conflict),
    .ld_use1      (ld_use1),
    .ld_use2      (ld_use2)
  );

  assign serial1 = head_if.head_is_privilege[0] | head_if.head_csr_write_en[0] | head_if.head_excp[0];
  assign serial2 = head_if.head_is_privilege[1] | head_if.head_csr_write_en[1] | head_if.head_excp[1];

  always_comb begin
    next_state = state;
    slot1      = 1'b0;
    slot2      = 1'b0;
    ld_take    = 1'b0;
    ld_addr    = head_if.head_wr_addr1;

    slot1 = head_if.head_valid[0] && (state == ST_RUN) && !ex_pause && !flush && !ld_use1 && !rst;
    slot2 = slot1 && head_if.head_valid[1] && !ld_use2 && !serial1 && !serial2
            && !mem_conflict && (head_if.head_alusel1 != ALUSEL_BRANCH) && !raw;

    // At most one load can issue per cycle because a load pair is a mem conflict
    if (slot1 && (head_if.head_alusel1 == ALUSEL_LOAD) && head_if.head_wr_en[0]
        && (head_if.head_wr_addr1 != 5'd0)) begin
      ld_take = 1'b1;
      ld_addr = head_if.head_wr_addr1;
    end else if (slot2 && (head_if.head_alusel2 == ALUSEL_LOAD) && head_if.head_wr_en[1]
                 && (head_if.head_wr_addr2 != 5'd0)) begin
      ld_take = 1'b1;
      ld_addr = head_if.head_wr_addr2;
    end

    if (flush) begin
      next_state = ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (slot1 && serial1) next_state = ST_DRAIN;
        ST_DRAIN: if (backend_empty && !ex_pause) next_state = ST_RUN;
        default:  next_state = ST_RUN;
      endcase
    end
  end

  assign head_if.issue_valid = {slot2, slot1};
  assign head_if.invalid_en  = {slot2, slot1};
  assign serial_busy         = (state == ST_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_RUN;
      last_ld_vld    <= 1'b0;
      dual_issue_cnt <= '0;
      stall_cnt      <= '0;
    end else begin
      state <= next_state;
      // A paused cycle must not consume the load-use bubble
      if (flush)          last_ld_vld <= 1'b0;
      else if (!ex_pause) last_ld_vld <= ld_take;
      if (slot1 && slot2)
        dual_issue_cnt <= dual_issue_cnt + CNT_WIDTH'(1);
      if (head_if.head_valid[0] && !slot1)
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ld_take) last_ld_addr <= ld_addr;
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed scenarios for issue_scheduler; expected per-cycle results go through
// a scoreboard queue and are compared when the outputs are sampled.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ex_pause;
  logic        backend_empty;
  logic        serial_busy;
  logic [31:0] dual_issue_cnt;
  logic [31:0] stall_cnt;

  issue_scheduler_if bus();

  issue_scheduler #(.CNT_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .head_if        (bus),
    .ex_pause       (ex_pause),
    .backend_empty  (backend_empty),
    .serial_busy    (serial_busy),
    .dual_issue_cnt (dual_issue_cnt),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [1:0]  issue;
    logic        busy;
    logic [31:0] dual;
    logic [31:0] stall;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_dual = 0;
  logic [31:0] exp_stall = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_head();
    bus.head_valid        = 2'b00;
    bus.head_alusel1      = ALUSEL_NOP;
    bus.head_alusel2      = ALUSEL_NOP;
    bus.head_rd_en1       = 2'b00;
    bus.head_rd_en2       = 2'b00;
    bus.head_rd_addr1     = 10'd0;
    bus.head_rd_addr2     = 10'd0;
    bus.head_wr_en        = 2'b00;
    bus.head_wr_addr1     = 5'd0;
    bus.head_wr_addr2     = 5'd0;
    bus.head_is_privilege = 2'b00;
    bus.head_csr_write_en = 2'b00;
    bus.head_excp         = 2'b00;
  endtask

  task automatic set_ent(input int i, input logic [2:0] alu, input logic [1:0] rden,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic wen, input logic [4:0] rd,
                         input logic csr = 1'b0, input logic excp = 1'b0, input logic priv = 1'b0);
    if (i == 0) begin
      bus.head_alusel1 = alu; bus.head_rd_en1 = rden; bus.head_rd_addr1 = {rs2, rs1};
      bus.head_wr_en[0] = wen; bus.head_wr_addr1 = rd;
    end else begin
      bus.head_alusel2 = alu; bus.head_rd_en2 = rden; bus.head_rd_addr2 = {rs2, rs1};
      bus.head_wr_en[1] = wen; bus.head_wr_addr2 = rd;
    end
    bus.head_csr_write_en[i] = csr;
    bus.head_excp[i]         = excp;
    bus.head_is_privilege[i] = priv;
  endtask

  // Inputs are already applied; push expectation, sample 1ns later, pop and compare
  task automatic cyc(input string tag, input logic [1:0] ei, input logic eb);
    exp_t e;
    e.tag = tag; e.issue = ei; e.busy = eb; e.dual = exp_dual; e.stall = exp_stall;
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    check({e.tag, ".issue"},  {30'd0, bus.issue_valid}, {30'd0, e.issue});
    check({e.tag, ".inval"},  {30'd0, bus.invalid_en},  {30'd0, e.issue});
    check({e.tag, ".busy"},   {31'd0, serial_busy},     {31'd0, e.busy});
    check({e.tag, ".dual"},   dual_issue_cnt,           e.dual);
    check({e.tag, ".stall"},  stall_cnt,                e.stall);
    if (rst) begin
      exp_dual  = 0;
      exp_stall = 0;
    end else begin
      if (ei == 2'b11) exp_dual++;
      if (bus.head_valid[0] && !ei[0]) exp_stall++;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ex_pause = 1'b0; backend_empty = 1'b0;
    clear_head();
    @(negedge clk);
    cyc("rst0", 2'b00, 1'b0);
    bus.head_valid = 2'b01;
    set_ent(0, ALUSEL_ALU, 2'b11, 5'd1, 5'd2, 1'b1, 5'd3);
    cyc("rst1", 2'b00, 1'b0);
    rst = 1'b0;

    // independent ALU pair
    clear_head(); bus.head_valid = 2'b11;
    set_ent(0, ALUSEL_ALU, 2'b11, 5'd2, 5'd3, 1'b1, 5'd1);
    set_ent(1, ALUSEL_ALU, 2'b11, 5'd3, 5'd4, 1'b1, 5'd2);
    cyc("t1_dual", 2'b11, 1'b0);
    clear_head();
    cyc("t1_idle", 2'b00, 1'b0);

    // RAW pair
    clear_head(); bus.head_valid = 2'b11;
    set_ent(0, ALUSEL_ALU, 2'b11, 5'd1, 5'd2, 1'b1, 5'd5);
    set_ent(1, ALUSEL_ALU, 2'b11, 5'd5, 5'd1, 1'b1, 5'd6);
    cyc("t2_raw", 2'b01, 1'b0);
    clear_head(); bus.head_valid = 2'b01;
    set_ent(0, ALUSEL_ALU, 2'b11, 5'd5, 5'd1, 1'b1, 5'd6);
    cyc("t2_shift", 2'b01, 1'b0);

    // load-use bubble at slot 1
    clear_head(); bus.head_valid = 2'b01;
    set_ent(0, ALUSEL_LOAD, 2'b01, 5'd1, 5'd0, 1'b1, 5'd4);
    cyc("t3_ld", 2'b01, 1'b0);
    set_ent(0, ALUSEL_ALU, 2'b01, 5'd4, 5'd0, 1'b1, 5'd7);
    cyc("t3_bubble", 2'b00, 1'b0);
    cyc("t3_use", 2'b01, 1'b0);
    set_ent(0, ALUSEL_LOAD, 2'b01, 5'd1, 5'd0, 1'b1, 5'd0);
    cyc("t3_ld_r0", 2'b01, 1'b0);
    set_ent(0, ALUSEL_ALU, 2'b01, 5'd0, 5'd0, 1'b1, 5'd7);
    cyc("t3_r0_nobub", 2'b01, 1'b0);

    // load issued from slot 2, used next cycle
    clear_head(); bus.head_valid = 2'b11;
    set_ent(0, ALUSEL_ALU, 2'b11, 5'd1, 5'd2, 1'b1, 5'd3);
    set_ent(1, ALUSEL_LOAD, 2'b01, 5'd1, 5'd0, 1'b1, 5'd9);
    cyc("t3_ld2", 2'b11, 1'b0);
    clear_head(); bus.head_valid = 2'b01;
    set_ent(0, ALUSEL_ALU, 2'b01, 5'd9, 5'd0, 1'b1, 5'd8);
    cyc("t3_ld2_bub", 2'b00, 1'b0);
    cyc("t3_ld2_use", 2'b01, 1'b0);

    // ex_pause does not consume the bubble
    clear_head(); bus.head_valid = 2'b01;
    set_ent(0, ALUSEL_LOAD, 2'b01, 5'd1, 5'd0, 1'b1, 5'd4);
    cyc("tp_ld", 2'b01, 1'b0);
    set_ent(0, ALUSEL_ALU, 2'b01, 5'd4, 5'd0, 1'b1, 5'd7);
    ex_pause = 1'b1;
    cyc("tp_pause", 2'b00, 1'b0);
    ex_pause = 1'b0;
    cyc("tp_bubble", 2'b00, 1'b0);
    cyc("tp_use", 2'b01, 1'b0);

    // load-use on slot 2 blocks only slot 2
    set_ent(0, ALUSEL_LOAD, 2'b01, 5'd1, 5'd0, 1'b1, 5'd4);
    cyc("tl2_ld", 2'b01, 1'b0);
    bus.head_valid = 2'b11;
    set_ent(0, ALUSEL_ALU, 2'b11, 5'd1, 5'd2, 1'b1, 5'd3);
    set_ent(1, ALUSEL_ALU, 2'b01, 5'd4, 5'd0, 1'b1, 5'd5);
    cyc("tl2_use", 2'b01, 1'b0);

    // pair restrictions: mem pair, branch first, serial at slot 2
    clear_head(); bus.head_valid = 2'b11;
    set_ent(0, ALUSEL_LOAD, 2'b01, 5'd1, 5'd0, 1'b1, 5'd10);
    set_ent(1, ALUSEL_STORE, 2'b11, 5'd2, 5'd3, 1'b0, 5'd0);
    cyc("tr_mem", 2'b01, 1'b0);
    set_ent(0, ALUSEL_BRANCH, 2'b11, 5'd1, 5'd2, 1'b0, 5'd0);
    set_ent(1, ALUSEL_ALU, 2'b11, 5'd2, 5'd3, 1'b1, 5'd11);
    cyc("tr_branch", 2'b01, 1'b0);
    set_ent(0, ALUSEL_ALU, 2'b11, 5'd1, 5'd2, 1'b1, 5'd12);
    set_ent(1, ALUSEL_ALU, 2'b11, 5'd2, 5'd3, 1'b1, 5'd13, 1'b0, 1'b0, 1'b1);
    cyc("tr_serial2", 2'b01, 1'b0);
    clear_head(); bus.head_valid = 2'b10;
    set_ent(1, ALUSEL_ALU, 2'b11, 5'd2, 5'd3, 1'b1, 5'd13);
    cyc("tr_young_only", 2'b00, 1'b0);

    // CSR write drains the backend
    clear_head(); bus.head_valid = 2'b11; backend_empty = 1'b0;
    set_ent(0, ALUSEL_ALU, 2'b11, 5'd1, 5'd2, 1'b1, 5'd1, 1'b1);
    set_ent(1, ALUSEL_ALU, 2'b11, 5'd2, 5'd3, 1'b1, 5'd14);
    cyc("t4_csr", 2'b01, 1'b0);
    set_ent(0, ALUSEL_ALU, 2'b11, 5'd2, 5'd3, 1'b1, 5'd14);
    set_ent(1, ALUSEL_ALU, 2'b11, 5'd3, 5'd4, 1'b1, 5'd15);
    for (int k = 0; k < 3; k++) cyc("t4_drain", 2'b00, 1'b1);
    backend_empty = 1'b1;
    cyc("t4_empty", 2'b00, 1'b1);
    cyc("t4_run", 2'b11, 1'b0);

    // flush in DRAIN with a pending load
    clear_head(); bus.head_valid = 2'b01; backend_empty = 1'b0;
    set_ent(0, ALUSEL_LOAD, 2'b01, 5'd1, 5'd0, 1'b1, 5'd4, 1'b0, 1'b1);
    cyc("t5_ldexc", 2'b01, 1'b0);
    set_ent(0, ALUSEL_ALU, 2'b01, 5'd4, 5'd0, 1'b1, 5'd7);
    flush = 1'b1;
    cyc("t5_flush", 2'b00, 1'b1);
    flush = 1'b0;
    cyc("t5_after", 2'b01, 1'b0);

    // reset during DRAIN
    set_ent(0, ALUSEL_ALU, 2'b11, 5'd1, 5'd2, 1'b1, 5'd1, 1'b1);
    cyc("t6_csr", 2'b01, 1'b0);
    set_ent(0, ALUSEL_ALU, 2'b11, 5'd1, 5'd2, 1'b1, 5'd3);
    cyc("t6_drain", 2'b00, 1'b1);
    rst = 1'b1;
    cyc("t6_rst_a", 2'b00, 1'b1);
    cyc("t6_rst_b", 2'b00, 1'b0);
    rst = 1'b0;
    cyc("t6_run", 2'b01, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
